axi_wr_slave_mem: RTL and testbench
===================================

// Module: axi_wr_slave_mem
// PURPOSE
//   AXI4 write-only slave that sits directly downstream of the HLS AXI write-burst master.
//   It accepts one AW burst descriptor and counts awlen+1 W beats; the master drives no wlast.
//   Each beat is written into a word-addressed on-chip SRAM port, then one B response is returned.
//   The read channel is out of scope: arready and rvalid are tied 0 at the integration level.
// PARAMETERS
//   ADDR_WIDTH      16  AXI byte-address width (awaddr)
//   DATA_WIDTH      32  AXI data width; multiple of 8
//   MEM_ADDR_WIDTH  14  SRAM word-address width; addresses wrap modulo 2**MEM_ADDR_WIDTH
// PORTS
//   clk             in   1               clock, rising edge
//   rst             in   1               asynchronous, active-low reset (0 = reset)
//   s_axi_awaddr    in   ADDR_WIDTH      burst start byte address
//   s_axi_awburst   in   2               0=FIXED 1=INCR 2=WRAP(unsupported) 3=reserved
//   s_axi_awlen     in   8               beats-1
//   s_axi_awsize    in   3               log2 bytes/beat
//   s_axi_awvalid   in   1               AW valid
//   s_axi_awready   out  1               AW ready
//   s_axi_wdata     in   DATA_WIDTH      beat data
//   s_axi_wstrb     in   DATA_WIDTH/8    byte enables
//   s_axi_wvalid    in   1               W valid
//   s_axi_wready    out  1               W ready
//   s_axi_bresp     out  2               0=OKAY, 2=SLVERR
//   s_axi_bvalid    out  1               B valid
//   s_axi_bready    in   1               B ready
//   mem_waddr       out  MEM_ADDR_WIDTH  SRAM word address
//   mem_wdata       out  DATA_WIDTH      SRAM write data
//   mem_wbe         out  DATA_WIDTH/8    SRAM byte enables
//   mem_wen         out  1               SRAM write strobe, one cycle per write
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE; every output 0 except s_axi_awready=1. A burst in progress is abandoned with no B response.
//   - FSM IDLE -> DATA -> RESP -> IDLE. Ready and valid outputs are pure functions of the registered state.
//   - IDLE: awready=1, wready=0, bvalid=0.
//     - On awvalid&&awready, latch word addr = awaddr[MEM_ADDR_WIDTH+LSB-1:LSB], where LSB=log2(DATA_WIDTH/8).
//     - Also latch len=awlen and burst type, clear beat_cnt, then go to DATA.
//     - err is latched 1 if awsize!=LSB or awburst>=2.
//   - DATA: awready=0, wready=1.
//     - Each wvalid&&wready beat registers the SRAM outputs for exactly the next cycle (1-cycle write latency):
//       mem_waddr=addr, mem_wdata=wdata, mem_wbe=wstrb, mem_wen = !err && (wstrb!=0).
//     - After each beat, INCR does addr+=1 (wraps at 2**MEM_ADDR_WIDTH); FIXED holds addr.
//     - The beat with beat_cnt==len is the last one; then go to RESP. beat_cnt is 8 bits and never overflows.
//     - wvalid low stalls the FSM indefinitely with no timeout.
//   - RESP: bvalid=1 and bresp = err ? 2'b10 : 2'b00. Both are held stable until bready.
//     - On bvalid&&bready go to IDLE. With bready tied high, bvalid lasts exactly 1 cycle.
//   - Err bursts still consume all len+1 beats but write nothing.
//   - awlen=0 gives a single beat; awlen=255 gives 256 beats.
//   - Beats presented while in IDLE or RESP are not accepted (wready=0), so early W data waits.
//   - A new AW cannot be accepted before the B handshake of the previous burst completes.
//   - The final mem write (cycle after the last beat) coincides with the first RESP cycle. No ordering hazard exists.
// STRUCTURE
//   - Shared package axi_pkg holds:
//     - AXI_BURST_FIXED/INCR/WRAP constants
//     - AXI_RESP_OKAY/SLVERR constants
//     - typedef wr_state_t {IDLE, DATA, RESP}
//   - One sub-module, axi_burst_addr: holds the word-address register.
//     - Inputs: load, start addr, burst type, step.
//     - Output: current addr, with INCR wrap and FIXED hold.
//   - FSM, beat counter and SRAM output registers stay in the top module.
// TESTING
//   1. AW addr=0x0010 len=3 INCR size=2, 4 beats D0..D3, wstrb=0xF -> mem writes at word 4,5,6,7; one B OKAY.
//   2. Beats 2 and 3 of case 1 are separated by 5 idle cycles (wvalid=0) -> no mem_wen during the gap; final B OKAY.
//   3. AW awsize=5 (32-byte), len=1 -> 2 beats accepted, mem_wen never asserted, bresp=2'b10.
//   4. AW addr=0xFFFC len=2 INCR -> writes at word 0x3FFF, 0x0000, 0x0001.
//   5. FIXED burst len=2 at word 8 -> three writes at word 8; beat with wstrb=0 -> no mem_wen for that beat.
//   6. rst=0 after 2 of 4 beats, then released -> awready=1 the next cycle, bvalid never asserted; a following 1-beat burst completes OKAY.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the write-slave FSM state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Burst word-address register: loads the start address, then steps per beat
// (INCR wraps at 2**MEM_ADDR_WIDTH, FIXED holds).
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [MEM_ADDR_WIDTH-1:0] start_addr,
  input  logic [1:0]                burst,
  input  logic                      step,
  output logic [MEM_ADDR_WIDTH-1:0] addr
);

  logic [1:0] burst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr    <= '0;
      burst_q <= AXI_BURST_FIXED;
    end else if (load) begin
      addr    <= start_addr;
      burst_q <= burst;
    end else if (step && (burst_q == AXI_BURST_INCR)) begin
      addr <= addr + MEM_ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axi_wr_slave_mem.sv
// AXI4 write-only slave: one AW burst, awlen+1 counted W beats (no wlast),
// each beat written to a word-addressed SRAM port, then one B response.
module axi_wr_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [1:0]                s_axi_awburst,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wbe,
  output logic                      mem_wen
);

  localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);

  wr_state_t                 state_q, state_d;
  logic [7:0]                len_q;
  logic [7:0]                beat_cnt;
  logic                      err_q;
  logic                      aw_fire, w_fire, last_beat;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^s_axi_awaddr;

  assign aw_fire   = s_axi_awvalid && s_axi_awready;
  assign w_fire    = s_axi_wvalid && s_axi_wready;
  assign last_beat = (beat_cnt == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = AXI_RESP_OKAY;
    case (state_q)
      IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) state_d = DATA;
      end
      DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && last_beat) state_d = RESP;
      end
      RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (s_axi_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // beat_cnt stops at len so awlen=255 never wraps the counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if (aw_fire) begin
      len_q    <= s_axi_awlen;
      beat_cnt <= '0;
      err_q    <= (s_axi_awsize != 3'(LSB)) || (s_axi_awburst >= AXI_BURST_WRAP);
    end else if (w_fire && !last_beat) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  axi_burst_addr #(
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_burst_addr (
    .clk       (clk),
    .rst       (rst),
    .load      (aw_fire),
    .start_addr(s_axi_awaddr[MEM_ADDR_WIDTH+LSB-1:LSB]),
    .burst     (s_axi_awburst),
    .step      (w_fire),
    .addr      (addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wbe   <= '0;
      mem_wen   <= 1'b0;
    end else if (w_fire) begin
      mem_waddr <= addr;
      mem_wdata <= s_axi_wdata;
      mem_wbe   <= s_axi_wstrb;
      mem_wen   <= !err_q && (s_axi_wstrb != '0);
    end else begin
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wbe   <= '0;
      mem_wen   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Randomized bench for axi_wr_slave_mem with a queue-based model of expected SRAM writes.
module tb_axi_wr_slave_mem;

  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] s_axi_awaddr = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [13:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbe;
  logic        mem_wen;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  axi_wr_slave_mem #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (32),
    .MEM_ADDR_WIDTH(14)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_awlen  (s_axi_awlen),
    .s_axi_awsize (s_axi_awsize),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wbe      (mem_wbe),
    .mem_wen      (mem_wen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every observed SRAM write must be the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst && mem_wen) begin
      if (exp_q.size() == 0) begin
        check("spurious_wen", mem_wen, 1'b0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("mem_waddr", mem_waddr, e.a);
        check("mem_wdata", mem_wdata, e.d);
        check("mem_wbe", mem_wbe, e.be);
      end
    end
  end

  task automatic send_aw(input logic [15:0] a, input logic [7:0] len,
                         input logic [1:0] bt, input logic [2:0] sz);
    int n = 0;
    s_axi_awaddr  = a;
    s_axi_awlen   = len;
    s_axi_awburst = bt;
    s_axi_awsize  = sz;
    s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("aw_wait", n < LIMIT, 1'b1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_awaddr  = $urandom;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] be,
                           input bit expect_wr, input logic [13:0] wa);
    int n = 0;
    s_axi_wdata  = d;
    s_axi_wstrb  = be;
    s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("w_wait", n < LIMIT, 1'b1);
    if (expect_wr) exp_q.push_back('{a: wa, d: d, be: be});
    @(negedge clk);
    s_axi_wvalid = 1'b0;
  endtask

  // Full burst: model computes each beat's word address from the AXI rules directly.
  task automatic run_burst(input logic [15:0] a, input logic [7:0] len, input logic [1:0] bt,
                           input logic [2:0] sz, input int gap_beat, input int gap_len,
                           input int zero_beat, input bit full_strb, input int bdelay);
    bit          err;
    int unsigned cur;
    int          n;
    logic [3:0]  be;
    err = (sz != 3'd2) || (bt >= 2'd2);
    cur = (int'(a) / 4) % 16384;
    @(negedge clk);
    send_aw(a, len, bt, sz);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == gap_beat) repeat (gap_len) @(negedge clk);
      if (i == zero_beat) be = 4'h0;
      else if (full_strb) be = 4'hF;
      else be = 4'($urandom_range(1, 15));
      send_beat($urandom, be, !err && (be != 4'h0), 14'(cur));
      if (bt == 2'd1) cur = (cur + 1) % 16384;
    end
    n = 0;
    while (!s_axi_bvalid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("b_wait", n < LIMIT, 1'b1);
    repeat (bdelay) begin
      check("b_hold_valid", s_axi_bvalid, 1'b1);
      check("b_hold_awready", s_axi_awready, 1'b0);
      @(negedge clk);
    end
    s_axi_bready = 1'b1;
    check("bvalid", s_axi_bvalid, 1'b1);
    check("bresp", s_axi_bresp, err ? 2'b10 : 2'b00);
    @(negedge clk);
    s_axi_bready = 1'b0;
    check("bvalid_drop", s_axi_bvalid, 1'b0);
    check("awready_back", s_axi_awready, 1'b1);
    check("writes_done", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_awready", s_axi_awready, 1'b1);
    check("rst_wready", s_axi_wready, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_bresp", s_axi_bresp, 2'b00);
    check("rst_mem_wen", mem_wen, 1'b0);
    check("rst_mem_waddr", mem_waddr, 14'h0);
    rst = 1'b1;
    @(negedge clk);

    run_burst(16'h0010, 8'd3, 2'd1, 3'd2, -1, 0, -1, 1'b1, 0);
    run_burst(16'h0010, 8'd3, 2'd1, 3'd2, 2, 5, -1, 1'b1, 0);
    run_burst(16'h0040, 8'd1, 2'd1, 3'd5, -1, 0, -1, 1'b1, 2);
    run_burst(16'hFFFC, 8'd2, 2'd1, 3'd2, -1, 0, -1, 1'b1, 0);
    run_burst(16'h0020, 8'd2, 2'd0, 3'd2, -1, 0, 1, 1'b1, 1);

    // Reset mid-burst: two of four beats sent, then the burst is abandoned.
    @(negedge clk);
    send_aw(16'h0100, 8'd3, 2'd1, 3'd2);
    send_beat(32'hA5A5_0001, 4'hF, 1'b1, 14'h0040);
    send_beat(32'hA5A5_0002, 4'hF, 1'b1, 14'h0041);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_awready", s_axi_awready, 1'b1);
    check("mid_rst_wready", s_axi_wready, 1'b0);
    check("mid_rst_bvalid", s_axi_bvalid, 1'b0);
    check("mid_rst_mem_wen", mem_wen, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_awready", s_axi_awready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("post_rst_bvalid", s_axi_bvalid, 1'b0);
    end
    run_burst(16'h0200, 8'd0, 2'd1, 3'd2, -1, 0, -1, 1'b1, 0);

    run_burst(16'($urandom), 8'd255, 2'd1, 3'd2, -1, 0, 7, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] bt;
      logic [2:0] sz;
      bt = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2;
      run_burst(16'($urandom), 8'($urandom_range(0, 7)), bt, sz,
                $urandom_range(0, 7), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1,
                1'b0, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
